// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter and sequencer for the shared 4-input operand mux
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] REQ,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  output logic [3:0] GNT,
  output logic [1:0] S,
  output logic [3:0] Y,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t     state, nextState;
  logic [1:0] priPtr, nextPri;
  logic [3:0] holdCnt, nextHc;
  logic [3:0] nextGnt;
  logic [1:0] nextS;
  logic [1:0] owner;
  logic [3:0] others;
  logic [3:0] muxOut;

  // First requester in rotating order starting at p.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] m);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && m[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] g);
    onehot = 4'b0001 << g;
  endfunction

  // The current owner is whatever S points at while a grant is held.
  assign owner  = S;
  assign others = REQ & ~onehot(owner);
  assign BUSY   = |GNT;

  // Next-state and next-grant decision, including hold-limit forced rotation.
  always_comb begin
    nextState = state;
    nextGnt   = GNT;
    nextS     = S;
    nextPri   = priPtr;
    nextHc    = holdCnt;
    case (state)
      IDLE: begin
        if (|REQ) begin
          nextS     = pick(priPtr, REQ);
          nextGnt   = onehot(nextS);
          nextHc    = 4'd1;
          nextState = GRANT;
        end
      end
      GRANT: begin
        if (!REQ[owner]) begin
          nextPri = owner + 2'd1;
          if (|REQ) begin
            nextS   = pick(owner + 2'd1, REQ);
            nextGnt = onehot(nextS);
            nextHc  = 4'd1;
          end else begin
            nextGnt   = 4'b0000;
            nextHc    = 4'd0;
            nextState = IDLE;
          end
        end else if (holdCnt == HOLD_LIM && |others) begin
          nextS   = pick(owner + 2'd1, others);
          nextGnt = onehot(nextS);
          nextPri = owner + 2'd1;
          nextHc  = 4'd1;
        end else if (holdCnt != HOLD_LIM) begin
          nextHc = holdCnt + 4'd1;
        end
      end
      default: begin
        nextState = IDLE;
        nextGnt   = 4'b0000;
      end
    endcase
  end

  // Operand selection using the registered select.
  always_comb begin
    muxOut = D0;
    case (S)
      2'd0: muxOut = D0;
      2'd1: muxOut = D1;
      2'd2: muxOut = D2;
      2'd3: muxOut = D3;
      default: muxOut = D0;
    endcase
  end

  // Control state register; reset wins over any grant in progress.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      GNT     <= 4'b0000;
      S       <= 2'd0;
      priPtr  <= 2'd0;
      holdCnt <= 4'd0;
    end else begin
      state   <= nextState;
      GNT     <= nextGnt;
      S       <= nextS;
      priPtr  <= nextPri;
      holdCnt <= nextHc;
    end
  end

  // Capture the granted operand one edge after the grant becomes visible.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      Y     <= 4'd0;
      VALID <= 1'b0;
    end else if (|GNT) begin
      Y     <= muxOut;
      VALID <= 1'b1;
    end else begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] REQ;
  logic [3:0] D0, D1, D2, D3;

  logic [3:0] gnt1, gnt2, gnt4;
  logic [1:0] s1, s2, s4;
  logic [3:0] y1, y2, y4;
  logic       valid1, valid2, valid4;
  logic       busy1, busy2, busy4;

  int nChecks = 0;
  int nFail   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(1)) u1 (
    .clock(clock), .reset_n(reset_n), .REQ(REQ),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .GNT(gnt1), .S(s1), .Y(y1), .VALID(valid1), .BUSY(busy1)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2)) u2 (
    .clock(clock), .reset_n(reset_n), .REQ(REQ),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .GNT(gnt2), .S(s2), .Y(y2), .VALID(valid2), .BUSY(busy2)
  );

  mux4_rr_arbiter #(.MAX_HOLD(4)) u4 (
    .clock(clock), .reset_n(reset_n), .REQ(REQ),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .GNT(gnt4), .S(s4), .Y(y4), .VALID(valid4), .BUSY(busy4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    REQ     = 4'b0000;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] expG [5];
    logic [1:0] expS [5];
    expG = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expS = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n = 1'b0;
    REQ = 4'b0000;
    D0 = 4'h0; D1 = 4'h0; D2 = 4'h0; D3 = 4'h0;
    tick();
    tick();
    chk("rst_gnt", gnt4, 4'b0000);
    chk("rst_s", s4, 2'd0);
    chk("rst_y", y4, 4'h0);
    chk("rst_valid", valid4, 1'b0);
    chk("rst_busy", busy4, 1'b0);

    // Single requester latency
    reset_n = 1'b1;
    REQ = 4'b0010;
    D1 = 4'h5;
    tick();
    chk("lat_e1_gnt", gnt4, 4'b0010);
    chk("lat_e1_s", s4, 2'd1);
    chk("lat_e1_busy", busy4, 1'b1);
    chk("lat_e1_valid", valid4, 1'b0);
    tick();
    chk("lat_e2_y", y4, 4'h5);
    chk("lat_e2_valid", valid4, 1'b1);
    tick();
    chk("lat_e3_gnt", gnt4, 4'b0010);
    REQ = 4'b0000;
    tick();
    chk("lat_e4_gnt", gnt4, 4'b0000);
    chk("lat_e4_busy", busy4, 1'b0);
    chk("lat_e4_valid", valid4, 1'b1);
    tick();
    chk("lat_e5_valid", valid4, 1'b0);
    chk("lat_e5_y", y4, 4'h5);
    chk("lat_e5_s_hold", s4, 2'd1);

    // Reset mid-grant
    REQ = 4'b0100;
    D2 = 4'hA;
    tick();
    chk("mid_gnt", gnt4, 4'b0100);
    tick();
    chk("mid_y", y4, 4'hA);
    chk("mid_valid", valid4, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_gnt", gnt4, 4'b0000);
    chk("mid_rst_s", s4, 2'd0);
    chk("mid_rst_y", y4, 4'h0);
    chk("mid_rst_valid", valid4, 1'b0);
    chk("mid_rst_busy", busy4, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("mid_regrant", gnt4, 4'b0100);

    // Round-robin fairness with MAX_HOLD=1
    doReset();
    D0 = 4'h1; D1 = 4'h2; D2 = 4'h3; D3 = 4'h4;
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), gnt1, expG[i]);
      chk($sformatf("rr_s%0d", i), s1, expS[i]);
      if (i > 0) chk($sformatf("rr_y%0d", i), y1, 4'(expS[i-1]) + 4'h1);
    end

    // Hold limit with MAX_HOLD=4
    doReset();
    REQ = 4'b0001;
    tick();
    chk("hold_c1", gnt4, 4'b0001);
    tick();
    chk("hold_c2", gnt4, 4'b0001);
    REQ = 4'b1001;
    tick();
    chk("hold_c3", gnt4, 4'b0001);
    tick();
    chk("hold_c4", gnt4, 4'b0001);
    tick();
    chk("hold_rot", gnt4, 4'b1000);
    chk("hold_rot_s", s4, 2'd3);
    tick();
    chk("hold_own3", gnt4, 4'b1000);
    REQ = 4'b0001;
    tick();
    chk("hold_back0", gnt4, 4'b0001);
    chk("hold_back0_busy", busy4, 1'b1);

    // Saturation with MAX_HOLD=2
    doReset();
    REQ = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sat_c%0d", i), gnt2, 4'b0100);
    end
    REQ = 4'b0101;
    tick();
    chk("sat_rot", gnt2, 4'b0001);
    chk("sat_rot_s", s2, 2'd0);

    // Priority wrap: owner 3 drops with 0 and 1 requesting
    doReset();
    REQ = 4'b1000;
    tick();
    chk("wrap_own3", gnt4, 4'b1000);
    REQ = 4'b0011;
    tick();
    chk("wrap_next0", gnt4, 4'b0001);
    chk("wrap_s", s4, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
